// File: rtl/vga_init_if.sv
// Video timing bus between the timing generator and downstream drawing stages.
// The master drives every field, and each slave only reads them.
interface vga_init_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: position counters plus sync/blank flags and line/frame strobes.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29
) (
  input  logic       clk,
  input  logic       rst,
  vga_init_if.master vga_out,
  output logic       frame_start,
`ifdef VGA_FRAME_CNT_EN
  output logic       line_start,
  output logic [15:0] frame_cnt
`else
  output logic       line_start
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLK    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYN_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYN_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLK    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYN_LO = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYN_HI = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        running;
  logic [10:0] hcount, vcount;
  logic [10:0] h_nxt, v_nxt;
  logic        hsync, vsync, hblnk, vblnk;
  logic        hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt;
  logic        frame_nxt, line_nxt;

  // The first cycle out of reset holds (0,0) so that it shows up with both strobes set.
  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (running) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? '0 : vcount + 11'd1;
      end else begin
        h_nxt = hcount + 11'd1;
      end
    end
  end

  always_comb begin
    hblnk_nxt = (h_nxt >= H_BLK);
    hsync_nxt = (h_nxt >= H_SYN_LO) && (h_nxt < H_SYN_HI);
    vblnk_nxt = (v_nxt >= V_BLK);
    vsync_nxt = (v_nxt >= V_SYN_LO) && (v_nxt < V_SYN_HI);
    line_nxt  = (h_nxt == '0);
    frame_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      running     <= 1'b1;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      frame_start <= frame_nxt;
      line_start  <= line_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts completed frames, so the frame_start that comes straight out of reset is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_nxt && running) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  assign vga_out.hcount = hcount;
  assign vga_out.vcount = vcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.vsync  = vsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vblnk  = vblnk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: a default XGA instance plus a small-timing instance
// so that multi-frame behaviour fits in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb, fs, ls;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic fs0, ls0, fs1, ls1;
  logic [15:0] fc0, fc1;

  vga_init_if bus0 ();
  vga_init_if bus1 ();

  always #5 clk = ~clk;

`ifdef VGA_FRAME_CNT_EN
  vga_timing_gen dut0 (.clk(clk), .rst(rst0), .vga_out(bus0), .frame_start(fs0),
                       .line_start(ls0), .frame_cnt(fc0));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                   .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3))
    dut1 (.clk(clk), .rst(rst1), .vga_out(bus1), .frame_start(fs1),
          .line_start(ls1), .frame_cnt(fc1));
`else
  vga_timing_gen dut0 (.clk(clk), .rst(rst0), .vga_out(bus0), .frame_start(fs0),
                       .line_start(ls0));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                   .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3))
    dut1 (.clk(clk), .rst(rst1), .vga_out(bus1), .frame_start(fs1),
          .line_start(ls1));
  assign fc0 = '0;
  assign fc1 = '0;
`endif

  int ha[2] = '{1024, 16};
  int hf[2] = '{24, 2};
  int hy[2] = '{136, 3};
  int hp[2] = '{160, 4};
  int va[2] = '{768, 10};
  int vf[2] = '{3, 1};
  int vy[2] = '{6, 2};
  int vp[2] = '{29, 3};

  int m_h[2], m_v[2], m_fc[2];
  bit m_run[2];
  obs_t q0[$], q1[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int hs_cnt0 = 0, vs_cnt1 = 0, last_fs1 = -1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Reference model: advances the expected raster position and pushes the output the DUT
  // should show after the coming clock edge.
  task automatic model(input int i, input logic r);
    obs_t e;
    int ht, vt;
    ht = ha[i] + hf[i] + hy[i] + hp[i];
    vt = va[i] + vf[i] + vy[i] + vp[i];
    e = '0;
    if (r) begin
      m_run[i] = 0; m_h[i] = 0; m_v[i] = 0; m_fc[i] = 0;
    end else begin
      if (!m_run[i]) begin
        m_run[i] = 1; m_h[i] = 0; m_v[i] = 0;
      end else begin
        m_h[i]++;
        if (m_h[i] == ht) begin
          m_h[i] = 0;
          m_v[i]++;
          if (m_v[i] == vt) begin
            m_v[i] = 0;
            m_fc[i] = (m_fc[i] + 1) % 65536;
          end
        end
      end
      e.h  = 11'(m_h[i]);
      e.v  = 11'(m_v[i]);
      e.hb = (m_h[i] >= ha[i]);
      e.hs = (m_h[i] >= ha[i] + hf[i]) && (m_h[i] < ha[i] + hf[i] + hy[i]);
      e.vb = (m_v[i] >= va[i]);
      e.vs = (m_v[i] >= va[i] + vf[i]) && (m_v[i] < va[i] + vf[i] + vy[i]);
      e.ls = (m_h[i] == 0);
      e.fs = (m_h[i] == 0) && (m_v[i] == 0);
    end
    e.fc = 16'(m_fc[i]);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic compare(input int i, input obs_t o);
    obs_t e;
    string p;
    p = $sformatf("u%0d.", i);
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      total++; bad++;
      $display("FAIL %sscoreboard_empty observed=0 expected=1", p);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    chk({p, "hcount"}, 32'(o.h), 32'(e.h));
    chk({p, "vcount"}, 32'(o.v), 32'(e.v));
    chk({p, "hsync"},  32'(o.hs), 32'(e.hs));
    chk({p, "vsync"},  32'(o.vs), 32'(e.vs));
    chk({p, "hblnk"},  32'(o.hb), 32'(e.hb));
    chk({p, "vblnk"},  32'(o.vb), 32'(e.vb));
    chk({p, "frame_start"}, 32'(o.fs), 32'(e.fs));
    chk({p, "line_start"},  32'(o.ls), 32'(e.ls));
`ifdef VGA_FRAME_CNT_EN
    chk({p, "frame_cnt"}, 32'(o.fc), 32'(e.fc));
`endif
  endtask

  task automatic tick();
    obs_t o0, o1;
    model(0, rst0);
    model(1, rst1);
    @(posedge clk);
    #1;
    cyc++;
    o0 = {bus0.hcount, bus0.vcount, bus0.hsync, bus0.vsync, bus0.hblnk, bus0.vblnk, fs0, ls0, fc0};
    o1 = {bus1.hcount, bus1.vcount, bus1.hsync, bus1.vsync, bus1.hblnk, bus1.vblnk, fs1, ls1, fc1};
    compare(0, o0);
    compare(1, o1);
    if (bus0.hsync === 1'b1) hs_cnt0++;
    if (bus1.vsync === 1'b1) vs_cnt1++;
    if (fs1 === 1'b1) begin
      if (last_fs1 >= 0) begin
        chk("u1.frame_period", 32'(cyc - last_fs1), 32'd400);
        chk("u1.vsync_cycles", 32'(vs_cnt1), 32'd50);
      end
      last_fs1 = cyc;
      vs_cnt1 = 0;
    end
    if (rst1) begin
      last_fs1 = -1;
      vs_cnt1 = 0;
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (5) tick();

    rst0 = 1'b0;
    rst1 = 1'b0;
    hs_cnt0 = 0;
    repeat (2 * 1344 + 10) tick();
    chk("u0.hsync_cycles_two_lines", 32'(hs_cnt0), 32'd272);

    // Mid-line reset on the XGA instance.
    for (int n = 0; n < 2000 && m_h[0] != 500; n++) tick();
    chk("u0.reached_h500", 32'(m_h[0]), 32'd500);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    tick();

    // Mid-frame reset on the small instance.
    for (int n = 0; n < 500 && !(m_h[1] == 8 && m_v[1] == 6); n++) tick();
    chk("u1.reached_h8_v6", 32'((m_h[1] == 8) && (m_v[1] == 6)), 32'd1);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    tick();

    repeat (3 * 400 + 5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
